// File: rtl/gate_bist_pkg.sv
// ============================================================================
// gate_bist_pkg: gate encodings, FSM states and vector order for gate_bist_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

package gate_bist_pkg;

  localparam logic [2:0] GATE_AND  = 3'd0;
  localparam logic [2:0] GATE_OR   = 3'd1;
  localparam logic [2:0] GATE_NAND = 3'd2;
  localparam logic [2:0] GATE_NOR  = 3'd3;
  localparam logic [2:0] GATE_XOR  = 3'd4;
  localparam logic [2:0] GATE_XNOR = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Vectors are {a, b}, walked 00 -> 01 -> 10 -> 11
  localparam logic [1:0] VEC_FIRST = 2'b00;
  localparam logic [1:0] VEC_LAST  = 2'b11;

  function automatic logic sel_valid(input logic [2:0] sel);
    return (sel <= GATE_XNOR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/gate_golden.sv
// ============================================================================
// gate_golden: combinational reference gate, y_exp = 0 for unused encodings
// Rev 1.0
// ============================================================================
`default_nettype none

module gate_golden
  import gate_bist_pkg::*;
(
  input  logic [2:0] sel_i,
  input  logic       a_i,
  input  logic       b_i,
  output logic       y_exp_o
);

  always_comb begin
    y_exp_o = 1'b0;
    case (sel_i)
      GATE_AND:  y_exp_o = a_i & b_i;
      GATE_OR:   y_exp_o = a_i | b_i;
      GATE_NAND: y_exp_o = ~(a_i & b_i);
      GATE_NOR:  y_exp_o = ~(a_i | b_i);
      GATE_XOR:  y_exp_o = a_i ^ b_i;
      GATE_XNOR: y_exp_o = ~(a_i ^ b_i);
      default:   y_exp_o = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/gate_bist_ctrl.sv
// ============================================================================
// gate_bist_ctrl: truth-table BIST sequencer for one external 2-input gate.
// Optional GATE_BIST_ERRLOG_EN adds first_fail_o capture. Rev 1.0
// ============================================================================
`default_nettype none

module gate_bist_ctrl
  import gate_bist_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int LOOPS      = 1,
  parameter int ERR_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [2:0]       gate_sel_i,
  output logic             dut_a_o,
  output logic             dut_b_o,
  input  logic             dut_y_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [ERR_W-1:0] err_cnt_o
`ifdef GATE_BIST_ERRLOG_EN
  ,
  output logic [3:0]       first_fail_o
`endif
);

  localparam int c_SET_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int c_LOOP_W = (LOOPS > 1) ? $clog2(LOOPS) : 1;
  localparam logic [c_SET_W-1:0]  c_SET_LOAD  = c_SET_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
  localparam logic [c_LOOP_W-1:0] c_LOOP_LAST = c_LOOP_W'(LOOPS - 1);

  state_e              state_q;
  logic [2:0]          sel_q;
  logic [1:0]          vec_q;
  logic [c_LOOP_W-1:0] loop_q;
  logic [c_SET_W-1:0]  settle_q;
  logic                busy_q;
  logic                done_q;
  logic                pass_q;
  logic [ERR_W-1:0]    err_q;
  logic [ERR_W-1:0]    err_d;
  logic                y_exp;
  logic                mismatch;
`ifdef GATE_BIST_ERRLOG_EN
  logic [3:0]          ff_q;
`endif

  gate_golden u_golden (
    .sel_i   (sel_q),
    .a_i     (vec_q[1]),
    .b_i     (vec_q[0]),
    .y_exp_o (y_exp)
  );

  always_comb begin
    mismatch = (dut_y_i != y_exp);
    err_d    = err_q;
    if (mismatch && (err_q != {ERR_W{1'b1}})) begin
      err_d = err_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= 3'd0;
      vec_q    <= VEC_FIRST;
      loop_q   <= '0;
      settle_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
`ifdef GATE_BIST_ERRLOG_EN
      ff_q     <= 4'd0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            err_q  <= '0;
            pass_q <= 1'b0;
`ifdef GATE_BIST_ERRLOG_EN
            ff_q   <= 4'd0;
`endif
            if (sel_valid(gate_sel_i)) begin
              state_q <= ST_APPLY;
              sel_q   <= gate_sel_i;
              vec_q   <= VEC_FIRST;
              loop_q  <= '0;
              busy_q  <= 1'b1;
            end else begin
              // Unsupported gate: report a failed run without touching the stimulus
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_APPLY: begin
          if (SETTLE_CYC > 0) begin
            state_q  <= ST_SETTLE;
            settle_q <= c_SET_LOAD;
          end else begin
            state_q <= ST_CHECK;
          end
        end
        ST_SETTLE: begin
          if (settle_q == '0) begin
            state_q <= ST_CHECK;
          end else begin
            settle_q <= settle_q - 1'b1;
          end
        end
        ST_CHECK: begin
          err_q <= err_d;
`ifdef GATE_BIST_ERRLOG_EN
          if (mismatch && !ff_q[3]) begin
            ff_q <= {1'b1, vec_q, dut_y_i};
          end
`endif
          if (vec_q == VEC_LAST) begin
            if (loop_q == c_LOOP_LAST) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_d == '0);
            end else begin
              loop_q  <= loop_q + 1'b1;
              vec_q   <= VEC_FIRST;
              state_q <= ST_APPLY;
            end
          end else begin
            vec_q   <= vec_q + 1'b1;
            state_q <= ST_APPLY;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign dut_a_o   = vec_q[1];
  assign dut_b_o   = vec_q[0];
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign pass_o    = pass_q;
  assign err_cnt_o = err_q;
`ifdef GATE_BIST_ERRLOG_EN
  assign first_fail_o = ff_q;
`endif

endmodule

`default_nettype wire
